mod_counter_sequencer: RTL
==========================

# mod_counter_sequencer

Programmable run controller for the team's modulo-N counter datapath. It accepts a counter configuration (terminal value and repeat count) over a valid/ready handshake, then starts, pauses, stops and completes counting runs. It emits terminal-count and run-done pulses. It sits between the system control logic and the counter core, replacing fixed-modulus counters, such as the MOD-14 counter, wherever the modulus or run length must change at run time.

## Interface
- `WIDTH`, 4, counter width; terminal value range 0..2^WIDTH-1
- `REP_W`, 8, repeat-count width
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `cfg_valid`  in  1  configuration offered
- `cfg_ready`  out  1  configuration accepted this cycle if `cfg_valid`; high only in IDLE
- `cfg_term`  in  WIDTH  terminal value T; the counter cycles 0..T, so modulus = T+1
- `cfg_reps`  in  REP_W  number of wraps R per run; 0 = run forever
- `start`  in  1  begin a run (honoured only in IDLE)
- `pause`  in  1  level; freezes counting while high
- `stop`  in  1  abort the run, return to IDLE without `done`
- `count`  out  WIDTH  current count value
- `tc`  out  1  terminal count: high while in RUN and `count == T`
- `rep_left`  out  REP_W  wraps remaining in the current run
- `busy`  out  1  high in RUN, HOLD and DONE
- `done`  out  1  one-cycle pulse: run completed normally

## Operation
- States:
  - IDLE: waiting for configuration or start.
  - RUN: counting.
  - HOLD: paused, count frozen.
  - DONE: one cycle, then IDLE.
- Reset values: state=IDLE, count=0, rep_left=0, T register=0, R register=0. Outputs: `cfg_ready`=1, `tc`=0, `busy`=0, `done`=0.
- Configuration handshake:
  - A transfer occurs when `cfg_valid && cfg_ready`.
  - The T and R registers capture the inputs on that edge.
  - A handshake in the same cycle as `start` uses the new values for that run.
- IDLE + `start`:
  - Go to RUN.
  - count←0.
  - rep_left←R, using the newly captured R if a same-cycle handshake occurs.
- RUN:
  - count increments by one per cycle.
  - When count==T: count←0 and `tc`=1 that cycle.
  - If R≠0: on each `tc`, rep_left decrements. When `tc` occurs with rep_left==1, go to DONE and set count←0.
  - If R==0: rep_left holds at 0 and the run never self-terminates.
- T==0: count stays at 0 and `tc` is high every RUN cycle.
- RUN + `pause`:
  - Go to HOLD; count and rep_left are frozen.
  - `tc`=0 in HOLD.
  - `pause` low → back to RUN, resuming from the frozen count.
- DONE: `done`=1 and `busy`=1 for exactly one cycle, then IDLE.
- Priority: `stop` > `pause` > counting.
  - `stop` in RUN, HOLD or DONE → IDLE, count←0, rep_left←0, no `done`.
  - `stop` in the same cycle as the final `tc` suppresses `done`.
- Ignored inputs:
  - `start` outside IDLE is ignored.
  - `pause` in IDLE or DONE is ignored.
  - `pause` and `start` together in IDLE: enter RUN; the pause takes effect on the next edge.
- Count arithmetic is WIDTH-bit unsigned. The count never exceeds T; the wrap is explicit, not overflow.

## Timing
- `start` sampled at edge 0 → after edge 0: RUN, count=0.
- After edge k (k ≤ T): count=k in the first repetition.
- `tc` is combinational from registered state and count: no extra latency.
- With R reps and no pause, the final `tc` is visible after edge R(T+1)-1.
- DONE/`done` is visible after edge R(T+1).
- IDLE is reached after edge R(T+1)+1.
- Each pause cycle delays all subsequent events by one cycle.
- `cfg_ready` is a pure decode of state==IDLE.
- `rst` asserted mid-run forces reset values immediately (asynchronous), with no `done`.

## Structure
- Shared package:
  - state enum (IDLE, RUN, HOLD, DONE)
  - default `WIDTH`/`REP_W` constants
- Sub-module `modn_counter_core`:
  - WIDTH-bit counter with `en`, `clr` and a `term` input
  - outputs `count` and `at_term`
- The sequencer FSM owns the T/R registers, rep_left, the handshake and the control decode.

## Test plan
- Reset, then config T=13, R=2, `start` → `tc` after edges 13 and 27, `done` after edge 28, IDLE after edge 29; `busy` high for cycles 0..28.
- T=13, R=0 → count wraps 13→0 indefinitely; `tc` every 14 cycles for at least 100 cycles; never `done`.
- T=5, R=1, `pause` for 3 cycles starting at count=2 → count holds at 2 and `tc`=0 while paused; `done` arrives 3 cycles later than the unpaused case (edge 9 instead of 6).
- T=3, R=4, `stop` in the same cycle as the final `tc` → IDLE, count=0, `done` never asserts. Then `start` with no new config → reruns with T=3, R=4.
- `cfg_valid` during RUN → `cfg_ready`=0 and T is unchanged. In IDLE, `cfg_valid` with T=0, R=3 plus `start` in the same cycle → `tc` high 3 consecutive cycles, then `done`.
- `rst` asserted mid-run at count=7 → count=0, `busy`=0, `cfg_ready`=1 immediately, before the next clock edge.

Source files
------------

// File: rtl/mod_counter_sequencer_pkg.sv
// Shared types and default widths for the modulo-N run controller.
package mod_counter_sequencer_pkg;

  localparam int unsigned DefWidth = 4;
  localparam int unsigned DefRepW  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHold,
    StDone
  } seq_state_e;

endpackage

// File: rtl/modn_counter_core.sv
// Width-bit counter that wraps to zero after reaching a programmable terminal value.
module modn_counter_core #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [Width-1:0] term_i,
  output logic [Width-1:0] count_o,
  output logic             at_term_o
);

  logic [Width-1:0] count_q, count_d;

  assign at_term_o = (count_q == term_i);
  assign count_o   = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = at_term_o ? '0 : count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mod_counter_sequencer.sv
// Run controller: captures terminal/repeat configuration and sequences counting runs.
module mod_counter_sequencer
  import mod_counter_sequencer_pkg::*;
#(
  parameter int unsigned Width = DefWidth,
  parameter int unsigned RepW  = DefRepW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [Width-1:0] cfg_term_i,
  input  logic [RepW-1:0]  cfg_reps_i,
  input  logic             start_i,
  input  logic             pause_i,
  input  logic             stop_i,
  output logic [Width-1:0] count_o,
  output logic             tc_o,
  output logic [RepW-1:0]  rep_left_o,
  output logic             busy_o,
  output logic             done_o
);

  seq_state_e      state_q;
  logic [Width-1:0] term_q;
  logic [RepW-1:0]  reps_q;
  logic [RepW-1:0]  rep_left_q;
  logic             hs;
  logic             cnt_en;
  logic             cnt_clr;
  logic             at_term;

  assign hs          = cfg_valid_i && (state_q == StIdle);
  assign cfg_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);
  assign tc_o        = (state_q == StRun) && at_term;
  assign rep_left_o  = rep_left_q;

  // Leaving HOLD counts on the same edge so each paused cycle costs exactly one cycle.
  always_comb begin
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    unique case (state_q)
      StIdle: cnt_clr = start_i;
      StRun, StHold: begin
        if (stop_i) begin
          cnt_clr = 1'b1;
        end else if (!pause_i) begin
          cnt_en = 1'b1;
        end
      end
      StDone: cnt_clr = 1'b1;
      default: cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      term_q     <= '0;
      reps_q     <= '0;
      rep_left_q <= '0;
    end else begin
      if (hs) begin
        term_q <= cfg_term_i;
        reps_q <= cfg_reps_i;
      end
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q    <= StRun;
            rep_left_q <= hs ? cfg_reps_i : reps_q;
          end
        end
        StRun, StHold: begin
          if (stop_i) begin
            state_q    <= StIdle;
            rep_left_q <= '0;
          end else if (pause_i) begin
            state_q <= StHold;
          end else begin
            state_q <= StRun;
            if (at_term && (reps_q != '0)) begin
              rep_left_q <= rep_left_q - RepW'(1);
              if (rep_left_q == RepW'(1)) begin
                state_q <= StDone;
              end
            end
          end
        end
        StDone: begin
          state_q    <= StIdle;
          rep_left_q <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  modn_counter_core #(
    .Width (Width)
  ) u_core (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (cnt_en),
    .clr_i     (cnt_clr),
    .term_i    (term_q),
    .count_o   (count_o),
    .at_term_o (at_term)
  );

endmodule
